// File: rtl/bcd_tick_pkg.sv
// bcd_tick_pkg: BCD digit types and single-digit increment, decrement and saturation helpers.
package bcd_tick_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic [BCD_DIGIT_W:0] bcd_digit_inc(input bcd_digit_t d);
        return (d >= BCD_MAX) ? {1'b1, BCD_MIN} : {1'b0, d + 4'd1};
    endfunction

    function automatic logic [BCD_DIGIT_W:0] bcd_digit_dec(input bcd_digit_t d);
        return (d == BCD_MIN) ? {1'b1, BCD_MAX} : {1'b0, d - 4'd1};
    endfunction

    function automatic bcd_digit_t bcd_sat(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: synchronizes an asynchronous divided clock and emits a rise pulse
// that is suppressed for SYNC_STAGES+1 cycles after reset release.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic tick_src,
    output logic rise
);

    localparam int ARM_CYC = SYNC_STAGES + 1;
    localparam int CW      = $clog2(ARM_CYC + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    logic [CW-1:0]          arm_cnt;
    logic                   arm;

    // A source held high through reset reaches sync_out before arm rises, so it never qualifies.
    assign arm  = (arm_cnt == CW'(ARM_CYC));
    assign rise = sync_q[SYNC_STAGES-1] & ~prev & arm;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            prev    <= 1'b0;
            arm_cnt <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], tick_src};
            prev    <= sync_q[SYNC_STAGES-1];
            if (!arm) arm_cnt <= arm_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: counts synchronized rising edges of a divided clock in a BCD up/down counter.
// Optional sticky overflow flag enabled by BCD_TICK_COUNTER_OVF_STICKY_EN.
module bcd_tick_counter
    import bcd_tick_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  tick_src,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  wrap
`ifdef BCD_TICK_COUNTER_OVF_STICKY_EN
    ,
    output logic                  ovf_sticky
`endif
);

    localparam int W = 4 * DIGITS;

    logic          rise;
    logic          step;
    logic [DIGITS:0] c;
    logic [W-1:0]  stepped;
    logic [W-1:0]  sat_val;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_in  (clk_in),
        .reset   (reset),
        .tick_src(tick_src),
        .rise    (rise)
    );

    assign c[0] = 1'b1;
    assign step = rise & en & ~clear & ~load;

    // c[i] is the carry/borrow into digit i; c[DIGITS] set means the whole count rolled over.
    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            bcd_digit_t        d;
            logic [4:0]        r;
            assign d                    = count[4*i +: 4];
            assign r                    = up ? bcd_digit_inc(d) : bcd_digit_dec(d);
            assign stepped[4*i +: 4]    = c[i] ? r[3:0] : d;
            assign c[i+1]               = c[i] & r[4];
            assign sat_val[4*i +: 4]    = bcd_sat(load_val[4*i +: 4]);
        end
    endgenerate

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            count <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            tick <= rise;
            wrap <= step & c[DIGITS];
            if (clear)     count <= '0;
            else if (load) count <= sat_val;
            else if (step) count <= stepped;
        end
    end

`ifdef BCD_TICK_COUNTER_OVF_STICKY_EN
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset)                  ovf_sticky <= 1'b0;
        else if (clear)              ovf_sticky <= 1'b0;
        else if (step & c[DIGITS])   ovf_sticky <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_bcd_tick_counter.sv
// tb_bcd_tick_counter: table-driven check of bcd_tick_counter plus reset/arming sequences.
module tb_bcd_tick_counter;

    logic        clk_in = 1'b0;
    logic        reset = 1'b0;
    logic        tick_src = 1'b0;
    logic        en = 1'b1;
    logic        up = 1'b1;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] count;
    logic        tick;
    logic        wrap;
    logic        ovf_sticky;

    int checks = 0;
    int errors = 0;

    bcd_tick_counter #(.DIGITS(4), .SYNC_STAGES(2)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .tick_src(tick_src),
        .en      (en),
        .up      (up),
        .clear   (clear),
        .load    (load),
        .load_val(load_val),
        .count   (count),
        .tick    (tick),
        .wrap    (wrap)
`ifdef BCD_TICK_COUNTER_OVF_STICKY_EN
        ,
        .ovf_sticky(ovf_sticky)
`endif
    );

`ifndef BCD_TICK_COUNTER_OVF_STICKY_EN
    assign ovf_sticky = 1'b0;
`endif

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        up;
        logic        en;
        logic        clr;
        logic        ld;
        logic [15:0] lv;
        logic [15:0] ecount;
        logic        ewrap;
        logic        eovf;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One tick_src pulse; clear/load are presented in the cycle the tick registers.
    task automatic step(input vec_t v, input string nm);
        logic early;
        up       = v.up;
        en       = v.en;
        load_val = v.lv;
        tick_src = 1'b1;
        early    = 1'b0;
        repeat (2) begin
            @(negedge clk_in);
            early |= tick;
        end
        chk({nm, " early_tick"}, {31'b0, early}, 32'd0);
        clear = v.clr;
        load  = v.ld;
        @(negedge clk_in);
        clear = 1'b0;
        load  = 1'b0;
        chk({nm, " tick"}, {31'b0, tick}, 32'd1);
        chk({nm, " count"}, {16'b0, count}, {16'b0, v.ecount});
        chk({nm, " wrap"}, {31'b0, wrap}, {31'b0, v.ewrap});
`ifdef BCD_TICK_COUNTER_OVF_STICKY_EN
        chk({nm, " ovf"}, {31'b0, ovf_sticky}, {31'b0, v.eovf});
`endif
        @(negedge clk_in);
        chk({nm, " pulse_end"}, {30'b0, tick, wrap}, 32'd0);
        tick_src = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    initial begin
        logic seen;
        vec_t v;
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h9998, 16'h9998, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9998, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0457, 16'h0457, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0457, 16'h0457, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h0100, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h9999, 16'h9999, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0099, 16'h0099, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0100, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0099, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hA3F1, 16'h9391, 1'b0, 1'b1};
        for (int k = 16; k < 21; k++)
            tbl[k] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9391, 1'b0, 1'b1};
        tbl[21] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0033, 16'h0033, 1'b0, 1'b1};

        // Reset with tick_src already high: no spurious tick after release.
        tick_src = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("reset_state", {15'b0, count, tick, wrap}, 32'd0);
        reset = 1'b1;
        seen  = 1'b0;
        repeat (10) begin
            @(negedge clk_in);
            seen |= tick;
        end
        chk("no_spurious_tick", {31'b0, seen}, 32'd0);
        chk("count_after_release", {16'b0, count}, 32'd0);
        tick_src = 1'b0;
        repeat (4) @(negedge clk_in);

        for (int n = 1; n <= 12; n++) begin
            v = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'((n / 10) * 16 + (n % 10)), 1'b0, 1'b0};
            step(v, $sformatf("edge%0d", n));
        end
        chk("count_12_edges", {16'b0, count}, 32'h0012);

        for (int k = 0; k < 22; k++) step(tbl[k], $sformatf("vec%0d", k));

        // Asynchronous reset mid-count clears immediately and re-arms.
        #2 reset = 1'b0;
        #1;
        chk("async_reset_count", {16'b0, count}, 32'd0);
        chk("async_reset_pulses", {30'b0, tick, wrap}, 32'd0);
        chk("async_reset_ovf", {31'b0, ovf_sticky}, 32'd0);
        @(negedge clk_in);
        reset    = 1'b1;
        tick_src = 1'b1;
        seen     = 1'b0;
        repeat (6) begin
            @(negedge clk_in);
            seen |= tick;
        end
        chk("rearm_no_tick", {31'b0, seen}, 32'd0);
        tick_src = 1'b0;
        repeat (4) @(negedge clk_in);
        v = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0};
        step(v, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
